// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register in-flight write tracker that stalls ID on RAW hazards or WAW count saturation
// Ports:
//   clk, rst_n                  clock and asynchronous active-low reset
//   issue_valid/writes/dest     instruction in ID and the register it will write
//   src1/src2, src1_use/src2_use  registers that instruction reads in ID
//   wb_valid, wb_dest           register-file write completing this cycle
//   flush_ex                    cancels the issue accepted on the previous edge
//   stall                       combinational hold of ID / bubble into ID/EX
//   busy_mask                   registered, bit i set while register i has pending writes
//   retire_err                  registered sticky flag: write-back with nothing pending
module reg_scoreboard #(
    parameter int NREG  = 32,
    parameter int AW    = 5,
    parameter int CNT_W = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            issue_valid,
    input  logic            issue_writes,
    input  logic [AW-1:0]   issue_dest,
    input  logic [AW-1:0]   src1,
    input  logic [AW-1:0]   src2,
    input  logic            src1_use,
    input  logic            src2_use,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_dest,
    input  logic            flush_ex,
    output logic            stall,
    output logic [NREG-1:0] busy_mask,
    output logic            retire_err
);
    localparam logic [CNT_W-1:0] MAX = '1;
    logic [NREG-1:0][CNT_W-1:0] cnt, nxt;
    logic [NREG-1:0] busy_nxt, err_v;
    logic last_valid;
    logic [AW-1:0] last_dest;
    logic haz1, haz2, waw, acc;
    // a single pending write retiring this cycle is visible to ID via the first-half regfile write
    assign haz1 = src1_use && src1 != '0 && cnt[src1] != '0 &&
                  !(cnt[src1] == CNT_W'(1) && wb_valid && wb_dest == src1);
    assign haz2 = src2_use && src2 != '0 && cnt[src2] != '0 &&
                  !(cnt[src2] == CNT_W'(1) && wb_valid && wb_dest == src2);
    assign waw = issue_writes && issue_dest != '0 && cnt[issue_dest] == MAX;
    assign stall = issue_valid && (haz1 || haz2 || waw);
    assign acc = issue_valid && !stall && issue_writes && issue_dest != '0;
    genvar i;
    for (i = 0; i < NREG; i++) begin : g_reg
        logic inc, dec_wb, dec_fl;
        logic [CNT_W:0] up, dn, d;
        assign inc    = i != 0 && acc && issue_dest == AW'(i);
        assign dec_wb = i != 0 && wb_valid && wb_dest == AW'(i);
        assign dec_fl = i != 0 && flush_ex && last_valid && last_dest == AW'(i);
        // issue, write-back and flush fold into one clamped update
        assign up = {1'b0, cnt[i]} + {{CNT_W{1'b0}}, inc};
        assign dn = {{CNT_W{1'b0}}, dec_wb} + {{CNT_W{1'b0}}, dec_fl};
        assign d  = up > dn ? up - dn : '0;
        assign nxt[i] = d > {1'b0, MAX} ? MAX : d[CNT_W-1:0];
        assign busy_nxt[i] = nxt[i] != '0;
        assign err_v[i] = dec_wb && cnt[i] == '0 && !inc;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            busy_mask  <= '0;
            retire_err <= 1'b0;
            last_valid <= 1'b0;
            last_dest  <= '0;
        end else begin
            cnt        <= nxt;
            busy_mask  <= busy_nxt;
            retire_err <= retire_err || (|err_v);
            last_valid <= acc;
            last_dest  <= issue_dest;
        end
    end
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: directed self-checking bench for reg_scoreboard
module tb_reg_scoreboard;
    logic clk, rst_n;
    logic issue_valid, issue_writes, src1_use, src2_use, wb_valid, flush_ex;
    logic [4:0] issue_dest, src1, src2, wb_dest;
    logic stall, retire_err;
    logic [31:0] busy_mask;
    int checks = 0;
    int failures = 0;

    reg_scoreboard dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_writes(issue_writes), .issue_dest(issue_dest),
        .src1(src1), .src2(src2), .src1_use(src1_use), .src2_use(src2_use),
        .wb_valid(wb_valid), .wb_dest(wb_dest), .flush_ex(flush_ex),
        .stall(stall), .busy_mask(busy_mask), .retire_err(retire_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        issue_valid = 0; issue_writes = 0; issue_dest = 0;
        src1 = 0; src2 = 0; src1_use = 0; src2_use = 0;
        wb_valid = 0; wb_dest = 0; flush_ex = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] d);
        idle();
        issue_valid = 1; issue_writes = 1; issue_dest = d;
    endtask

    task automatic wb(input logic [4:0] d);
        idle();
        wb_valid = 1; wb_dest = d;
    endtask

    initial begin
        idle();
        rst_n = 0;
        tick(); tick();
        rst_n = 1;
        tick();
        check("reset_busy", busy_mask, 32'h0);
        check("reset_err", {31'b0, retire_err}, 32'h0);
        check("reset_stall", {31'b0, stall}, 32'h0);

        // reset mid-stream with two writes pending on r8
        issue(8); tick(); tick();
        check("r8_busy", busy_mask, 32'h100);
        idle(); issue_valid = 1; src1 = 8; src1_use = 1;
        #1 check("r8_raw_stall", {31'b0, stall}, 32'h1);
        rst_n = 0;
        #1;
        check("async_rst_busy", busy_mask, 32'h0);
        check("async_rst_stall", {31'b0, stall}, 32'h0);
        check("async_rst_err", {31'b0, retire_err}, 32'h0);
        tick(); rst_n = 1; tick();
        check("post_rst_stall", {31'b0, stall}, 32'h0);

        // RAW on r9 with same-cycle write-back bypass
        issue(9); tick();
        check("r9_busy", busy_mask, 32'h200);
        idle(); issue_valid = 1; src1 = 9; src1_use = 1;
        #1 check("r9_stall_a", {31'b0, stall}, 32'h1);
        tick();
        check("r9_stall_b", {31'b0, stall}, 32'h1);
        issue_valid = 0;
        #1 check("no_valid_no_stall", {31'b0, stall}, 32'h0);
        issue_valid = 1; wb_valid = 1; wb_dest = 9;
        #1 check("r9_bypass", {31'b0, stall}, 32'h0);
        tick();
        check("r9_cleared", busy_mask, 32'h0);

        // register 0 is never tracked
        issue(0); src1 = 0; src2 = 0; src1_use = 1; src2_use = 1;
        #1 check("r0_stall", {31'b0, stall}, 32'h0);
        tick();
        check("r0_busy", busy_mask, 32'h0);
        wb(0); tick();
        check("r0_wb_err", {31'b0, retire_err}, 32'h0);

        // WAW saturation on r5
        for (int k = 0; k < 3; k++) begin
            issue(5);
            #1 check("r5_accept", {31'b0, stall}, 32'h0);
            tick();
        end
        check("r5_busy", busy_mask, 32'h20);
        issue(5);
        #1 check("r5_waw_stall", {31'b0, stall}, 32'h1);
        wb_valid = 1; wb_dest = 5;
        #1 check("r5_waw_wb_stall", {31'b0, stall}, 32'h1);
        tick();
        wb_valid = 0;
        #1 check("r5_waw_release", {31'b0, stall}, 32'h0);
        tick();
        src1 = 5; src1_use = 1; wb_valid = 1; wb_dest = 5; issue_valid = 1; issue_writes = 0;
        #1 check("r5_cnt3_no_bypass", {31'b0, stall}, 32'h1);
        for (int k = 0; k < 3; k++) begin
            wb(5); tick();
        end
        check("r5_drained", busy_mask, 32'h0);
        check("r5_no_err", {31'b0, retire_err}, 32'h0);

        // flush cancels the previous cycle's accepted issue only
        issue(12); tick();
        check("r12_busy", busy_mask, 32'h1000);
        idle(); flush_ex = 1; tick();
        check("r12_flushed", busy_mask, 32'h0);
        issue(13); tick();
        idle(); tick();
        flush_ex = 1; tick();
        check("r13_stale_flush", busy_mask, 32'h2000);
        wb(13); tick();
        check("r13_cleared", busy_mask, 32'h0);

        // simultaneous events
        issue(7); tick();
        issue(7); wb_valid = 1; wb_dest = 7;
        #1 check("r7_issue_ok", {31'b0, stall}, 32'h0);
        tick();
        check("r7_issue_wb_busy", busy_mask, 32'h80);
        check("r7_no_err", {31'b0, retire_err}, 32'h0);
        idle(); issue_valid = 1; src2 = 7; src2_use = 1;
        #1 check("r7_src2_stall", {31'b0, stall}, 32'h1);
        wb(7); tick();
        issue(14); tick();
        wb(14); flush_ex = 1; tick();
        check("r14_wb_flush_busy", busy_mask, 32'h0);
        check("r14_wb_flush_err", {31'b0, retire_err}, 32'h0);

        // write-back with nothing pending sets a sticky error
        wb(20); tick();
        check("r20_err", {31'b0, retire_err}, 32'h1);
        idle(); tick(); tick();
        check("r20_err_sticky", {31'b0, retire_err}, 32'h1);
        check("final_busy", busy_mask, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
